// File: rtl/accelerator_scalar_scheduler_pkg.sv
// Shared types and constants for the scalar-exponentiator scheduler family.
package accelerator_scalar_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      DELIVER = 2'd3
   } sched_state_e;

   localparam int ZERO_DATA              = 0;
   localparam int ZERO_CONTROL           = 0;
   localparam int ONE_CONTROL            = 1;
   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/accelerator_round_robin_arbiter.sv
// Combinational round-robin pick: first pending index after last_i, wrapping modulo REQUESTERS.
module accelerator_round_robin_arbiter #(
   parameter int REQUESTERS   = 4,
   parameter int CONTROL_SIZE = 4
) (
   input  logic [REQUESTERS-1:0]   pending_i,
   input  logic [CONTROL_SIZE-1:0] last_i,
   output logic [CONTROL_SIZE-1:0] grant_o,
   output logic                    valid_o
);

   // Scan offsets from farthest to nearest so the nearest pending client is the final assignment.
   always_comb begin
      int idx;
      grant_o = '0;
      valid_o = 1'b0;
      idx     = 0;
      for (int k = REQUESTERS; k >= 1; k--) begin
         idx = (int'(last_i) + k) % REQUESTERS;
         for (int j = 0; j < REQUESTERS; j++) begin
            if ((j == idx) && pending_i[j]) begin
               grant_o = CONTROL_SIZE'(j);
               valid_o = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/accelerator_scalar_exponentiator_scheduler.sv
// Time-shares one scalar exponentiator between REQUESTERS clients with round-robin
// arbitration and a bounded wait for the unit's answer.
module accelerator_scalar_exponentiator_scheduler
   import accelerator_scalar_scheduler_pkg::*;
#(
   parameter int DATA_SIZE      = 64,
   parameter int CONTROL_SIZE   = 4,
   parameter int REQUESTERS     = 4,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic [REQUESTERS-1:0]            REQ_START,
   input  logic [REQUESTERS*DATA_SIZE-1:0]  REQ_DATA_IN,
   output logic [REQUESTERS-1:0]            REQ_READY,
   output logic [DATA_SIZE-1:0]             REQ_DATA_OUT,
   output logic                             REQ_ERROR,
   output logic                             EXP_START,
   output logic [DATA_SIZE-1:0]             EXP_DATA_IN,
   input  logic                             EXP_READY,
   input  logic [DATA_SIZE-1:0]             EXP_DATA_OUT,
   output logic [CONTROL_SIZE-1:0]          GRANT,
   output logic                             BUSY
);

   localparam int CNT_W = 2 * CONTROL_SIZE;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   sched_state_e                state_q, state_d;
   logic [CONTROL_SIZE-1:0]     grant_q, grant_d;
   logic [CONTROL_SIZE-1:0]     last_q, last_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic [DATA_SIZE-1:0]        result_q, result_d;
   logic                        error_q, error_d;
   logic [DATA_SIZE-1:0]        exp_data_q, exp_data_d;
   logic [REQUESTERS-1:0]       pending_q, pending_d;
   logic [DATA_SIZE-1:0]        operand_q [REQUESTERS];
   logic [DATA_SIZE-1:0]        operand_d [REQUESTERS];

   logic [REQUESTERS-1:0]       take;
   logic [REQUESTERS-1:0]       clear;
   logic [CONTROL_SIZE-1:0]     arb_grant;
   logic                        arb_valid;
   logic [DATA_SIZE-1:0]        sel_operand;

   accelerator_round_robin_arbiter #(
      .REQUESTERS   (REQUESTERS),
      .CONTROL_SIZE (CONTROL_SIZE)
   ) u_arbiter (
      .pending_i (pending_q),
      .last_i    (last_q),
      .grant_o   (arb_grant),
      .valid_o   (arb_valid)
   );

   // A fresh pulse is accepted when idle-pending, or when it coincides with that client's delivery.
   for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_client
      assign clear[gi] = (state_q == DELIVER) && (grant_q == CONTROL_SIZE'(gi));
      assign take[gi]  = REQ_START[gi] && (!pending_q[gi] || clear[gi]);
   end

   always_comb begin
      pending_d = pending_q;
      operand_d = operand_q;
      for (int i = 0; i < REQUESTERS; i++) begin
         if (take[i]) begin
            pending_d[i] = 1'b1;
            operand_d[i] = REQ_DATA_IN[i*DATA_SIZE +: DATA_SIZE];
         end else if (clear[i]) begin
            pending_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      sel_operand = DATA_SIZE'(ZERO_DATA);
      for (int i = 0; i < REQUESTERS; i++) begin
         if (arb_grant == CONTROL_SIZE'(i)) begin
            sel_operand = operand_q[i];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      count_d    = count_q;
      result_d   = result_q;
      error_d    = error_q;
      exp_data_d = exp_data_q;
      case (state_q)
         IDLE: begin
            // Operand is frozen while pending, so loading it here equals operand[GRANT] in ISSUE.
            if (arb_valid) begin
               grant_d    = arb_grant;
               exp_data_d = sel_operand;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            count_d = CNT_W'(ZERO_CONTROL);
            state_d = WAIT;
         end
         WAIT: begin
            if (EXP_READY) begin
               result_d = EXP_DATA_OUT;
               error_d  = 1'b0;
               state_d  = DELIVER;
            end else if (count_q == TIMEOUT_LAST) begin
               result_d = DATA_SIZE'(ZERO_DATA);
               error_d  = 1'b1;
               state_d  = DELIVER;
            end else begin
               count_d = count_q + CNT_W'(ONE_CONTROL);
            end
         end
         DELIVER: begin
            last_d  = grant_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         grant_q    <= CONTROL_SIZE'(ZERO_CONTROL);
         last_q     <= CONTROL_SIZE'(REQUESTERS - 1);
         count_q    <= CNT_W'(ZERO_CONTROL);
         result_q   <= DATA_SIZE'(ZERO_DATA);
         error_q    <= 1'b0;
         exp_data_q <= DATA_SIZE'(ZERO_DATA);
         pending_q  <= '0;
         for (int i = 0; i < REQUESTERS; i++) begin
            operand_q[i] <= DATA_SIZE'(ZERO_DATA);
         end
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         count_q    <= count_d;
         result_q   <= result_d;
         error_q    <= error_d;
         exp_data_q <= exp_data_d;
         pending_q  <= pending_d;
         operand_q  <= operand_d;
      end
   end

   assign REQ_READY    = clear;
   assign REQ_DATA_OUT = (state_q == DELIVER) ? result_q : DATA_SIZE'(ZERO_DATA);
   assign REQ_ERROR    = (state_q == DELIVER) && error_q;
   assign EXP_START    = (state_q == ISSUE);
   assign EXP_DATA_IN  = exp_data_q;
   assign GRANT        = grant_q;
   assign BUSY         = (state_q != IDLE);

endmodule

// File: doc/accelerator_scalar_exponentiator_scheduler.md
Name: accelerator_scalar_exponentiator_scheduler

Overview:
- Shares one accelerator_scalar_exponentiator_function instance between REQUESTERS clients using round-robin arbitration.
- Latches each client's one-cycle START pulse and operand, then sequences the shared unit's START/READY handshake.
- Returns the result to the granted client; aborts with an error flag if the unit never answers.
- Sits between the NTM controller lanes and the scalar math library.

Parameters:
- DATA_SIZE, 64, operand/result width.
- CONTROL_SIZE, 4, width of the grant index and the internal counters.
- REQUESTERS, 4, number of clients; range 2..2^CONTROL_SIZE.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before abort; range 1..2^(2*CONTROL_SIZE)-1.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- REQ_START  in  REQUESTERS  per-client one-cycle request pulse
- REQ_DATA_IN  in  REQUESTERS*DATA_SIZE  per-client operand; client i occupies bits [i*DATA_SIZE +: DATA_SIZE]
- REQ_READY  out  REQUESTERS  per-client one-cycle completion pulse
- REQ_DATA_OUT  out  DATA_SIZE  result, valid while REQ_READY is nonzero
- REQ_ERROR  out  1  high with REQ_READY when the operation timed out
- EXP_START  out  1  start pulse to the shared unit
- EXP_DATA_IN  out  DATA_SIZE  operand to the shared unit
- EXP_READY  in  1  completion from the shared unit
- EXP_DATA_OUT  in  DATA_SIZE  result from the shared unit
- GRANT  out  CONTROL_SIZE  index of the client in service
- BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset (RST=1 at a clock edge):
  - All outputs go to 0, all pending bits and latched operands clear, FSM enters IDLE.
  - Round-robin pointer LAST = REQUESTERS-1, so client 0 has first priority.
  - Reset mid-operation drops all in-flight work; no REQ_READY is issued for it.
- Capture, every cycle:
  - If REQ_START[i]=1 and pending[i]=0: pending[i] is set and operand[i] latches REQ_DATA_IN slice i.
  - If pending[i]=1 already: the pulse and its data are ignored; the original operand is kept.
  - If a new pulse for the client being cleared in DELIVER arrives in the same cycle: set wins and the new operand is latched.
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - If any pending bit is set, select the first pending index scanning LAST+1, LAST+2, ... modulo REQUESTERS.
  - Register it into GRANT and go to ISSUE.
- ISSUE (1 cycle):
  - EXP_START=1 and EXP_DATA_IN=operand[GRANT]; clear the timeout counter; go to WAIT.
  - EXP_DATA_IN holds this value unchanged through WAIT.
- WAIT:
  - EXP_START=0. EXP_READY is sampled only in this state; EXP_READY during ISSUE is ignored.
  - EXP_READY=1: latch EXP_DATA_OUT into the result register, error=0, go to DELIVER.
  - Else, counter == TIMEOUT_CYCLES-1: result=0, error=1, go to DELIVER.
  - Else: increment the counter.
- DELIVER (1 cycle):
  - REQ_READY[GRANT]=1, REQ_DATA_OUT=result, REQ_ERROR=error.
  - Clear pending[GRANT], set LAST=GRANT, go to IDLE.
  - REQ_DATA_OUT and REQ_ERROR return to 0 the following cycle.
- Latency: REQ_START at cycle t with the unit idle gives pending at t+1, IDLE decision at t+1, ISSUE at t+2, WAIT from t+3.
  - If the unit answers after k WAIT cycles (READY seen in the k-th), DELIVER is at t+3+k.
  - Minimum is t+4.
- Only one EXP_START is issued per grant; exactly one REQ_READY is issued per accepted request.
- Width rules: the counter is 2*CONTROL_SIZE bits; REQUESTERS is not a power of two in general, so the modulo must be explicit.

Decomposition:
- Package accelerator_scalar_scheduler_pkg holds:
  - the state enum (IDLE=0, ISSUE=1, WAIT=2, DELIVER=3);
  - ZERO_DATA, ZERO_CONTROL and ONE_CONTROL constants;
  - the default TIMEOUT_CYCLES.
- One sub-module, accelerator_round_robin_arbiter: purely combinational.
  - Inputs: pending vector and LAST. Outputs: grant index and grant-valid.
  - Reused by future vector/matrix schedulers.

Test Plan:
- Single request: REQ_START[1] pulse, operand 0x5, unit answers 0xA after 3 WAIT cycles → EXP_DATA_IN=0x5 with one EXP_START pulse; REQ_READY[1] pulse with REQ_DATA_OUT=0xA, REQ_ERROR=0.
- Simultaneous requests: REQ_START[0] and [2] in the same cycle after reset → client 0 served first, then client 2; GRANT sequence 0,2.
- Fairness: all four clients kept pending continuously → service order 0,1,2,3,0,1; no client is served twice while another waits.
- Timeout: TIMEOUT_CYCLES=8, unit never asserts EXP_READY → DELIVER after 8 WAIT cycles; REQ_READY[g]=1, REQ_ERROR=1, REQ_DATA_OUT=0; the next pending request proceeds.
- Duplicate pulse: REQ_START[3] with 0x11, then again with 0x22 while pending → unit receives 0x11 only; exactly one REQ_READY[3].
- Reset in WAIT: assert RST for one cycle while client 2 is in service → all outputs 0 next cycle, no REQ_READY[2]; a fresh request from client 1 is then served normally.
